hex_to_word: RTL and testbench

HEX_TO_WORD -- requirements
Module: hex_to_word

---
 rtl/hex_to_word.sv | 120 ++++++++++++
 tb/tb_hex_to_word.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hex_to_word.sv
// Renders an integer as "0x" + uppercase hex digits + terminator, one ASCII
// character at a time over a valid/ready stream toward a UART transmitter.
module hex_to_word #(
  parameter int         DATA       = 32,
  parameter bit         FULL_WIDTH = 1'b0,
  parameter logic [7:0] TERM       = 8'h20
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [DATA-1:0] i_data,
  output logic            o_ready,
  output logic [7:0]      o_char,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_last
);

  localparam int N  = DATA / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PFX0  = 3'd1;
  localparam logic [2:0] ST_PFX1  = 3'd2;
  localparam logic [2:0] ST_DIGIT = 3'd3;
  localparam logic [2:0] ST_TERM  = 3'd4;

  logic [2:0]      state;
  logic [DATA-1:0] data_q;
  logic [IW-1:0]   idx;
  logic            accept;
  logic            hs;

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    hex_char = (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  function automatic logic [3:0] nibble(input logic [DATA-1:0] v, input logic [IW-1:0] k);
    nibble = '0;
    for (int unsigned i = 0; i < N; i++)
      if (k == IW'(i)) nibble = v[4*i +: 4];
  endfunction

  // Highest nonzero nibble wins; a zero value still yields index 0, so one digit is emitted.
  function automatic logic [IW-1:0] first_index(input logic [DATA-1:0] v);
    first_index = '0;
    if (FULL_WIDTH) begin
      first_index = IW'(N - 1);
    end else begin
      for (int unsigned i = 0; i < N; i++)
        if (v[4*i +: 4] != 4'h0) first_index = IW'(i);
    end
  endfunction

  assign o_ready = (state == ST_IDLE) && !i_rst;
  assign accept  = i_valid && o_ready;
  assign hs      = o_valid && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      data_q  <= '0;
      idx     <= '0;
      o_char  <= 8'h00;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_q  <= i_data;
            idx     <= first_index(i_data);
            o_char  <= 8'h30;
            o_valid <= 1'b1;
            o_last  <= 1'b0;
            state   <= ST_PFX0;
          end
        end
        ST_PFX0: begin
          if (hs) begin
            o_char <= 8'h78;
            state  <= ST_PFX1;
          end
        end
        ST_PFX1: begin
          if (hs) begin
            o_char <= hex_char(nibble(data_q, idx));
            state  <= ST_DIGIT;
          end
        end
        ST_DIGIT: begin
          if (hs) begin
            if (idx == '0) begin
              o_char <= TERM;
              o_last <= 1'b1;
              state  <= ST_TERM;
            end else begin
              idx    <= idx - IW'(1);
              o_char <= hex_char(nibble(data_q, idx - IW'(1)));
            end
          end
        end
        ST_TERM: begin
          if (hs) begin
            o_char  <= 8'h00;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_to_word.sv
// Randomized self-checking bench for hex_to_word: instance 0 suppresses
// leading zeros, instance 1 emits all eight digits.
module tb_hex_to_word;

  typedef byte bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin   [2];
  logic [31:0] din   [2];
  logic        rdin  [2];
  logic        rdy   [2];
  logic [7:0]  oc    [2];
  logic        ov    [2];
  logic        ol    [2];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  byte         got[$];
  bit          lasts[$];

  always #5 clk = ~clk;

  hex_to_word #(.DATA(32), .FULL_WIDTH(1'b0), .TERM(8'h20)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(vin[0]), .i_data(din[0]), .o_ready(rdy[0]),
    .o_char(oc[0]), .o_valid(ov[0]), .i_ready(rdin[0]), .o_last(ol[0])
  );

  hex_to_word #(.DATA(32), .FULL_WIDTH(1'b1), .TERM(8'h20)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(vin[1]), .i_data(din[1]), .o_ready(rdy[1]),
    .o_char(oc[1]), .o_valid(ov[1]), .i_ready(rdin[1]), .o_last(ol[1])
  );

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference: "0x" + minimal (or full 8) uppercase hex digits + space.
  function automatic bq_t model(input logic [31:0] v, input bit fw);
    bq_t         q;
    string       hexs = "0123456789ABCDEF";
    logic [63:0] vv   = {32'h0, v};
    int          nd   = fw ? 8 : 1;
    if (!fw)
      for (int k = 1; k < 8; k++)
        if (vv >= (64'd1 << (4 * k))) nd = k + 1;
    q.push_back(8'h30);
    q.push_back(8'h78);
    for (int k = nd - 1; k >= 0; k--) q.push_back(hexs[int'((vv >> (4 * k)) % 16)]);
    q.push_back(8'h20);
    return q;
  endfunction

  task automatic run_word(input int s, input logic [31:0] v, input int stall_pct,
                          input int stall_at, input bit flood);
    bq_t         exp;
    int          budget;
    int          bubbles;
    bit          done;
    bit          stalled;
    logic [63:0] val;
    exp = model(v, s == 1);
    got.delete();
    lasts.delete();
    budget = 0;
    while (!rdy[s] && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("accept_wait", 64'(rdy[s]), 64'd1);
    vin[s] = 1'b1;
    din[s] = v;
    @(negedge clk);
    if (!flood) vin[s] = 1'b0;
    bubbles = 0;
    done    = 1'b0;
    stalled = 1'b0;
    budget  = 0;
    while (!done && budget < 400) begin
      if (flood) din[s] = $urandom;
      if (stall_at >= 0 && got.size() == stall_at && !stalled) begin
        stalled = 1'b1;
        rdin[s] = 1'b0;
        repeat (5) begin
          check("stall_valid", 64'(ov[s]), 64'd1);
          check("stall_char", 64'(oc[s]), 64'(exp[stall_at]));
          @(negedge clk);
          budget++;
        end
      end
      rdin[s] = ($urandom_range(99) >= stall_pct);
      if (!ov[s]) bubbles++;
      if (ov[s] && rdin[s]) begin
        got.push_back(oc[s]);
        lasts.push_back(ol[s]);
        if (ol[s]) done = 1'b1;
      end
      @(negedge clk);
      budget++;
    end
    vin[s]  = 1'b0;
    rdin[s] = 1'b0;
    check("timeout", 64'(done), 64'd1);
    check("ready_back", 64'(rdy[s]), 64'd1);
    check("bubbles", 64'(bubbles), 64'd0);
    check("length", 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      check("char", 64'(got[i]), 64'(exp[i]));
      check("last", 64'(lasts[i]), 64'(i == exp.size() - 1));
    end
    val = '1;
    if (got.size() >= 4 && got[0] == 8'h30 && got[1] == 8'h78) begin
      val = '0;
      for (int i = 2; i < got.size() - 1; i++)
        val = (val << 4) + 64'((got[i] >= 8'h41) ? (got[i] - 8'h41 + 10) : (got[i] - 8'h30));
    end
    check("parse", val, {32'h0, v});
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      vin[s]  = 1'b0;
      din[s]  = '0;
      rdin[s] = 1'b0;
    end
    #1;
    check("rst_valid", 64'(ov[0]), 64'd0);
    check("rst_last", 64'(ol[0]), 64'd0);
    check("rst_char", 64'(oc[0]), 64'h00);
    check("rst_ready", 64'(rdy[0]), 64'd0);
    #2 rst = 1'b0;
    #1 check("ready_after_rst", 64'(rdy[0]), 64'd1);

    run_word(0, 32'h0000BEEF, 0, -1, 1'b0);
    run_word(0, 32'h00000000, 0, -1, 1'b0);
    run_word(1, 32'h00000000, 0, -1, 1'b0);
    run_word(1, 32'hA0000001, 0, 2, 1'b0);
    run_word(0, 32'h00000012, 0, -1, 1'b1);
    run_word(0, 32'h00000034, 0, -1, 1'b0);

    // Async reset partway through 0xFFFF, just after the "x" transfers.
    @(negedge clk);
    vin[0]  = 1'b1;
    din[0]  = 32'h0000FFFF;
    rdin[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 64'(ov[0]), 64'd0);
    check("midrst_char", 64'(oc[0]), 64'h00);
    check("midrst_ready", 64'(rdy[0]), 64'd0);
    rst = 1'b0;
    #0.5 check("release_ready", 64'(rdy[0]), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("abandoned", 64'(ov[0]), 64'd0);
    end
    rdin[0] = 1'b0;
    run_word(0, 32'h00000005, 0, -1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] r;
      r = $urandom;
      if (n % 3 == 1) r = r >> ($urandom_range(31));
      run_word(n % 2, r, 40, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
